// File: rtl/pipe_subtractor8_pkg.sv
// pipe_subtractor8_pkg: shared constants and width-legality check for the pipelined subtractor
package pipe_subtractor8_pkg;
   localparam int NIBBLE_W = 4;
   function automatic bit width_ok(input int w);
      return w > 0 && w % 8 == 0;
   endfunction
endpackage

// File: rtl/pipe_subtractor8_cla_nibble.sv
// cla_nibble: 4-bit generate/propagate carry-lookahead adder slice
module cla_nibble
   import pipe_subtractor8_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);
   logic [3:0] w_g, w_p;
   logic [4:0] w_c;
   assign w_g = x & y;
   assign w_p = x ^ y;
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & cin);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                 | (&w_p[3:0] & cin);
   assign s = w_p ^ w_c[3:0];
   assign cout = w_c[4];
endmodule

// File: rtl/pipe_subtractor8.sv
// pipe_subtractor8: two-stage pipelined a - b (a + ~b + 1) with borrow/ovf/zero and valid/ready
module pipe_subtractor8
   import pipe_subtractor8_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);
   localparam int H  = WIDTH / 2;
   localparam int NN = H / NIBBLE_W;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("pipe_subtractor8: WIDTH must be a positive multiple of 8");
   end

   logic             w_s1_adv, w_s2_adv, w_acc;
   logic [H-1:0]     w_dlo, w_dhi;
   logic [NN:0]      w_cl, w_ch;
   logic             r_s1_valid, r_c;
   logic [H-1:0]     r_lo, r_ah, r_bh;
   logic             r_s2_valid, r_borrow, r_ovf, r_zero;
   logic [WIDTH-1:0] r_diff;

   assign w_s2_adv = ~r_s2_valid | out_ready;
   assign w_s1_adv = ~r_s1_valid | w_s2_adv;
   assign w_acc    = w_s1_adv & in_valid;
   assign in_ready = w_s1_adv;

   // Low half carries the +1 of the two's complement; high half resumes from the registered carry
   assign w_cl[0] = 1'b1;
   assign w_ch[0] = r_c;
   for (genvar n = 0; n < NN; n++) begin : g_nib
      cla_nibble u_lo (
         .x(a[n*NIBBLE_W +: NIBBLE_W]), .y(~b[n*NIBBLE_W +: NIBBLE_W]),
         .cin(w_cl[n]), .s(w_dlo[n*NIBBLE_W +: NIBBLE_W]), .cout(w_cl[n+1])
      );
      cla_nibble u_hi (
         .x(r_ah[n*NIBBLE_W +: NIBBLE_W]), .y(~r_bh[n*NIBBLE_W +: NIBBLE_W]),
         .cin(w_ch[n]), .s(w_dhi[n*NIBBLE_W +: NIBBLE_W]), .cout(w_ch[n+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_c        <= 1'b0;
         r_lo       <= '0;
         r_ah       <= '0;
         r_bh       <= '0;
      end else begin
         if (w_s1_adv) r_s1_valid <= in_valid;
         if (w_acc) begin
            r_lo <= w_dlo;
            r_c  <= w_cl[NN];
            r_ah <= a[WIDTH-1:H];
            r_bh <= b[WIDTH-1:H];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_diff     <= '0;
         r_borrow   <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         if (w_s2_adv) r_s2_valid <= r_s1_valid;
         if (w_s2_adv & r_s1_valid) begin
            r_diff   <= {w_dhi, r_lo};
            r_borrow <= ~w_ch[NN];
            r_ovf    <= (r_ah[H-1] ^ r_bh[H-1]) & (w_dhi[H-1] ^ r_ah[H-1]);
            r_zero   <= ~|{w_dhi, r_lo};
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign diff      = r_diff;
   assign borrow    = r_borrow;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
endmodule

// File: doc/pipe_subtractor8.md
Name: pipe_subtractor8

Overview:
- Two-stage pipelined two's-complement subtractor: diff = a - b, with borrow, signed-overflow and zero flags.
- It is the inverse-direction companion to the team's 8-bit nibble-CLA adder, built from the same nibble carry-lookahead slices as a + ~b + 1.
- Has a valid/ready handshake on input and output, so it sits in the datapath between an operand source and a result sink that may stall.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of 8.
- Stage 1 computes the low WIDTH/2 bits; stage 2 computes the high WIDTH/2 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Sole clock domain.
- in_valid  input  1  operand pair a/b presented.
- in_ready  output  1  block accepts the pair this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result presented.
- out_ready  input  1  sink accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow  output  1  1 iff unsigned a < b.
- ovf  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - s1_valid and s2_valid clear to 0.
  - out_valid=0, diff=0, borrow=0, ovf=0, zero=0.
  - in_ready=1 from the first cycle after reset.
- Arithmetic: diff = a + ~b + 1, realised as a chain of 4-bit CLA slices with carry-in 1 at bit 0.
  - borrow = ~carry_out of the MSB slice.
  - ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]).
  - zero = ~|diff.
- Stage 1 (on accept):
  - Computes the low half of diff and the carry out of the low half.
  - Registers the low diff, that carry, a[high], b[high], and s1_valid=1.
- Stage 2:
  - Computes the high half from the registered carry.
  - Registers the full diff, borrow, ovf, zero, and s2_valid=1.
  - out_valid = s2_valid.
- Latency: exactly 2 cycles from accept (in_valid & in_ready at edge N) to out_valid at edge N+2, when no stall occurs. Throughput is 1 result per cycle.
- Handshake and stall rules:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- Hold rules:
  - While out_valid=1 and out_ready=0: diff and all flags are held stable, and stage 1 holds if full.
  - a and b are sampled only on accept; changing them while in_ready=0 has no effect.
- Bubbles:
  - Stage 1 empties (s1_valid->0) when it advances with no new input.
  - Stage 2 empties when its result is taken and s1_valid=0.
- Simultaneous events:
  - Output taken, stage 1 advancing and a new input accepted on the same edge: all three happen, no loss or duplication.
  - in_valid=0 while full and out_ready=1: the pipeline drains one stage per cycle.
- Boundaries:
  - a == b gives diff=0, zero=1, borrow=0, ovf=0.
  - 0 - 1 gives all-ones with borrow=1.
  - Most-negative minus 1 gives ovf=1.
- Reset mid-operation: in-flight results are discarded immediately; no output is produced for operands accepted before reset.
- X-propagation: the data registers load only on advance, so garbage a/b with in_valid=0 never reaches diff.

Decomposition:
- Shared package: NIBBLE_W=4 and the WIDTH-legality rule (multiple of 8) as a constant or check function. No new typedefs needed.
- One natural sub-module, cla_nibble: 4-bit generate/propagate carry-lookahead slice with ports x, y, cin, s, cout. Instantiated WIDTH/4 times, with y = ~b slice.
- Pipeline control and the flag logic stay in the top level.

Test Plan:
- Reset, then a=0x35, b=0x12 with out_ready=1 held -> out_valid rises exactly 2 cycles after accept; diff=0x23, borrow=0, ovf=0, zero=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x5A, b=0x5A -> diff=0x00, zero=1.
- Back-to-back stream of 0x10-0x01, 0x20-0x02, 0x30-0x03, one per cycle -> results 0x0F, 0x1E, 0x2D on 3 consecutive cycles in order.
- Fill the pipe, then out_ready=0 for 5 cycles -> in_ready falls once both stages are full. diff stays 0x0F throughout; then out_ready=1 -> the remaining results emerge in order, none dropped or duplicated.
- Assert rst_n=0 for 1 cycle while both stages hold valid data -> out_valid=0 and all outputs 0 immediately (asynchronous). No stale result appears after release.
- Randomised 10k operand pairs with random in_valid/out_ready -> every result equals the reference model (a-b) mod 256, with borrow=(a<b) and ovf from the signed compare.
